bidir_link_ctrl: RTL and testbench

BIDIR_LINK_CTRL -- requirements
Module: bidir_link_ctrl

---
 rtl/bidir_link_pkg.sv | 33 +++
 rtl/bidir_link_ctrl_if.sv | 19 +
 rtl/bit_timer.sv | 34 +++
 rtl/bidir_link_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_bidir_link_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bidir_link_pkg.sv
// Shared types and frame constants for the single-wire link controller.
// Build option: PARITY_EN selects the 11-bit frame with an even-parity bit.
package bidir_link_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TX      = 3'd1,
        TURN    = 3'd2,
        RX_WAIT = 3'd3,
        RX      = 3'd4
    } link_state_e;

    localparam int unsigned TURN_MULT        = 2;
    localparam int unsigned FRAME_BITS_PAR   = 11;
    localparam int unsigned FRAME_BITS_NOPAR = 10;
    localparam int unsigned BIT_IDX_W        = 4;

`ifdef PARITY_EN
    localparam int unsigned FRAME_BITS = FRAME_BITS_PAR;
`else
    localparam int unsigned FRAME_BITS = FRAME_BITS_NOPAR;
`endif

    // Wire-order frame, bit 0 is sent first: start, data LSB first, [parity], stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
`ifdef PARITY_EN
        return {1'b1, ^data, data, 1'b0};
`else
        return {1'b1, data, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/bidir_link_ctrl_if.sv
// Request/response handshake bundle between a requester and the link controller.
interface bidir_link_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_err
    );
endinterface

// File: rtl/bit_timer.sv
// Bit-time divider with end-of-bit and mid-bit strobes.
// skip=1 on start makes the start cycle itself count as clock 0 of the bit.
module bit_timer #(
    parameter int unsigned BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic skip,
    output logic bit_end_c,
    output logic mid_bit_c
);

    localparam int unsigned CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(BIT_DIV / 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= skip ? CNT_W'(1) : '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign bit_end_c = en && !start && (cnt == LAST);
    assign mid_bit_c = en && !start && (cnt == MID);

endmodule

// File: rtl/bidir_link_ctrl.sv
// Half-duplex single-wire link: send one request frame, turn the line around, receive one reply.
// Build option: define PARITY_EN for even parity on both directions.
module bidir_link_ctrl
    import bidir_link_pkg::*;
#(
    parameter int unsigned BIT_DIV = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    bidir_link_ctrl_if.slave bus,
    inout  wire              bidir_signal,
    output logic             output_enable
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TURN_W = (TURN_MULT > 1) ? $clog2(TURN_MULT) : 1;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(FRAME_BITS - 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [TURN_W-1:0]    TURN_LAST = TURN_W'(TURN_MULT - 1);

    link_state_e state_q, state_d;

    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_bits;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [TURN_W-1:0]     turn_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [1:0]            sync_q;
    logic                  line_s;

    logic tmr_en, tmr_start, tmr_skip;
    logic bit_end_c, mid_bit_c;
    logic frame_ok_c;

    bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (tmr_en),
        .start     (tmr_start),
        .skip      (tmr_skip),
        .bit_end_c (bit_end_c),
        .mid_bit_c (mid_bit_c)
    );

    assign bidir_signal = output_enable ? tx_shift[0] : 1'bz;
    assign line_s       = sync_q[1];

    // Received frame is good when start was low, stop high and parity (if any) even.
`ifdef PARITY_EN
    assign frame_ok_c = !rx_bits[0] && rx_bits[FRAME_BITS-1] && !(^rx_bits[9:1]);
`else
    assign frame_ok_c = !rx_bits[0] && rx_bits[FRAME_BITS-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bidir_signal};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A result strobe is always held for one cycle before returning to IDLE.
    always_comb begin
        state_d   = state_q;
        tmr_en    = 1'b0;
        tmr_start = 1'b0;
        tmr_skip  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_d   = TX;
                    tmr_start = 1'b1;
                end
            end
            TX: begin
                tmr_en = 1'b1;
                if (bit_end_c && (bit_idx == LAST_BIT)) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                tmr_en = 1'b1;
                if (bit_end_c && (turn_cnt == TURN_LAST)) begin
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (bus.rx_err) begin
                    state_d = IDLE;
                end else if (!line_s) begin
                    state_d   = RX;
                    tmr_start = 1'b1;
                    tmr_skip  = 1'b1;
                end
            end
            RX: begin
                tmr_en = 1'b1;
                if (bus.rx_valid || bus.rx_err) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_enable <= 1'b0;
            bus.tx_ready  <= 1'b1;
            bus.rx_valid  <= 1'b0;
            bus.rx_err    <= 1'b0;
            bus.rx_data   <= 8'h00;
            tx_shift      <= '1;
            rx_bits       <= '1;
            bit_idx       <= '0;
            turn_cnt      <= '0;
            wait_cnt      <= '0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.rx_err    <= 1'b0;
            bus.tx_ready  <= (state_d == IDLE);
            output_enable <= (state_d == TX);
            case (state_q)
                IDLE: begin
                    if (bus.tx_valid) begin
                        tx_shift <= build_frame(bus.tx_data);
                        bit_idx  <= '0;
                    end
                end
                TX: begin
                    if (bit_end_c) begin
                        tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
                        bit_idx  <= (bit_idx == LAST_BIT) ? '0 : bit_idx + BIT_IDX_W'(1);
                    end
                end
                TURN: begin
                    wait_cnt <= '0;
                    if (bit_end_c) begin
                        turn_cnt <= (turn_cnt == TURN_LAST) ? '0 : turn_cnt + TURN_W'(1);
                    end
                end
                RX_WAIT: begin
                    if (!bus.rx_err) begin
                        if (!line_s) begin
                            bit_idx <= '0;
                        end else if (wait_cnt == WAIT_LAST) begin
                            bus.rx_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                RX: begin
                    if (mid_bit_c) begin
                        rx_bits <= {line_s, rx_bits[FRAME_BITS-1:1]};
                    end
                    if (bit_end_c) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (frame_ok_c) begin
                                bus.rx_data  <= rx_bits[8:1];
                                bus.rx_valid <= 1'b1;
                            end else begin
                                bus.rx_err <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_link_ctrl.sv
// Self-checking bench for bidir_link_ctrl: vector table, corner sequences and random replies.
module tb_bidir_link_ctrl;
    import bidir_link_pkg::*;

    localparam int BD = 4;
    localparam int TO = 64;
    localparam int NB = int'(FRAME_BITS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic far_val = 1'b1;
    logic output_enable;
    wire  line;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_rx_data;

    bidir_link_ctrl_if bus();

    bidir_link_ctrl #(.BIT_DIV(BD), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .bidir_signal  (line),
        .output_enable (output_enable)
    );

    // Far end: idles high whenever the controller is not driving.
    assign line = output_enable ? 1'bz : far_val;

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] txb;
        bit         reply;
        logic [7:0] rb;
        int         delay;
        bit         bad_stop;
        bit         bad_par;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Wire-order frame as the far end would see or send it.
    function automatic logic [10:0] frame_of(input logic [7:0] d, input bit bad_stop, input bit bad_par);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (NB == 11) begin
            f[9]  = ($countones(d) % 2 == 1) ^ bad_par;
            f[10] = !bad_stop;
        end else begin
            f[9] = !bad_stop;
        end
        return f;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({tag, " ready_timeout"}, 32'(n), 32'(0));
    endtask

    task automatic run_txn(input string tag, input logic [7:0] txb, input bit reply,
                           input logic [7:0] rb, input int delay, input bit bad_stop,
                           input bit bad_par, output int t_pulse, output bit got_v,
                           output bit got_e, output logic [7:0] got_d);
        logic [10:0] exp_tx, obs_tx, rf;
        int bad_cyc, limit;
        exp_tx  = frame_of(txb, 1'b0, 1'b0);
        rf      = frame_of(rb, bad_stop, bad_par);
        t_pulse = -1;
        got_v   = 1'b0;
        got_e   = 1'b0;
        got_d   = 8'hxx;
        wait_ready(tag);
        bus.tx_data  = txb;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        bad_cyc = 0;
        obs_tx  = '0;
        for (int c = 0; c < NB*BD; c++) begin
            if (output_enable !== 1'b1 || line !== exp_tx[c/BD]) bad_cyc++;
            if (bus.rx_valid !== 1'b0 || bus.rx_err !== 1'b0 || bus.tx_ready !== 1'b0) bad_cyc++;
            if (c % BD == BD/2) obs_tx[c/BD] = line;
            @(negedge clk);
        end
        check({tag, " tx_frame"}, 32'(obs_tx), 32'(exp_tx));
        check({tag, " tx_bad_cycles"}, 32'(bad_cyc), 32'(0));
        bad_cyc = 0;
        for (int c = 0; c < 2*BD; c++) begin
            if (output_enable !== 1'b0 || line !== 1'b1 || bus.rx_valid !== 1'b0 || bus.rx_err !== 1'b0) bad_cyc++;
            @(negedge clk);
        end
        check({tag, " turn_bad_cycles"}, 32'(bad_cyc), 32'(0));
        limit = delay + NB*BD + TO + 8;
        for (int t = 0; t < limit; t++) begin
            if (reply && t >= delay && t < delay + NB*BD) far_val = rf[(t-delay)/BD];
            else far_val = 1'b1;
            if (output_enable !== 1'b0) bad_cyc++;
            if (bus.rx_valid === 1'b1 || bus.rx_err === 1'b1) begin
                t_pulse = t;
                got_v   = bus.rx_valid;
                got_e   = bus.rx_err;
                got_d   = bus.rx_data;
                break;
            end
            @(negedge clk);
        end
        far_val = 1'b1;
        check({tag, " rx_phase_oe"}, 32'(bad_cyc), 32'(0));
        @(negedge clk);
        check({tag, " ready_after"}, 32'({bus.tx_ready, bus.rx_valid, bus.rx_err}), 32'(3'b100));
    endtask

    initial begin
        vec_t vecs[$];
        int t_pulse, exp_t, accepts, oe_bad, cyc;
        int acc_cyc[$];
        int pulse_cyc[$];
        bit got_v, got_e, exp_oe, exp_ok, reply, bad_stop, bad_par;
        logic [7:0] got_d, txb, rb;
        int delay;

        vecs.push_back('{8'hA5, 1'b0, 8'h00, 0,  1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{8'h5A, 1'b1, 8'h3C, 5,  1'b0, 1'b0, 1'b1, 8'h3C});
        vecs.push_back('{8'h00, 1'b1, 8'hC3, 0,  1'b1, 1'b0, 1'b0, 8'h3C});
        vecs.push_back('{8'hFF, 1'b1, 8'h81, 20, 1'b0, 1'b0, 1'b1, 8'h81});
`ifdef PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 8'h55, 3,  1'b0, 1'b1, 1'b0, 8'h81});
`endif
        vecs.push_back('{8'h3C, 1'b1, 8'h00, TO-3, 1'b0, 1'b0, 1'b1, 8'h00});

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        exp_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({output_enable, bus.tx_ready, bus.rx_valid, bus.rx_err}), 32'(4'b0100));
        check("reset_rx_data", 32'(bus.rx_data), 32'(8'h00));
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors.
        foreach (vecs[i]) begin
            run_txn($sformatf("vec%0d", i), vecs[i].txb, vecs[i].reply, vecs[i].rb, vecs[i].delay,
                    vecs[i].bad_stop, vecs[i].bad_par, t_pulse, got_v, got_e, got_d);
            exp_t = vecs[i].reply ? vecs[i].delay + 2 + NB*BD : TO;
            check($sformatf("vec%0d latency", i), 32'(t_pulse), 32'(exp_t));
            check($sformatf("vec%0d rx_valid", i), 32'(got_v), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d rx_err", i), 32'(got_e), 32'(!vecs[i].exp_valid));
            check($sformatf("vec%0d rx_data", i), 32'(got_d), 32'(vecs[i].exp_data));
            exp_rx_data = vecs[i].exp_data;
        end

        // Reset in the middle of TX bit 4.
        wait_ready("rst_mid");
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (4*BD) @(negedge clk);
        check("rst_mid driving", 32'(output_enable), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid state", 32'({output_enable, bus.tx_ready, bus.rx_valid, bus.rx_err}), 32'(4'b0100));
        check("rst_mid rx_data", 32'(bus.rx_data), 32'(8'h00));
        exp_rx_data = 8'h00;
        oe_bad = 0;
        for (int c = 0; c < 3*TO; c++) begin
            if (output_enable !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_err !== 1'b0 || bus.tx_ready !== 1'b1) oe_bad++;
            @(negedge clk);
        end
        check("rst_mid quiet", 32'(oe_bad), 32'(0));

        // tx_valid held across two transactions, far end silent.
        oe_bad = 0;
        bus.tx_data  = 8'h96;
        bus.tx_valid = 1'b1;
        for (cyc = 0; cyc < 1000 && pulse_cyc.size() < 2; cyc++) begin
            exp_oe = 1'b0;
            foreach (acc_cyc[k]) if (cyc > acc_cyc[k] && cyc <= acc_cyc[k] + NB*BD) exp_oe = 1'b1;
            if (output_enable !== exp_oe) oe_bad++;
            if (bus.rx_valid === 1'b1 || bus.rx_err === 1'b1) pulse_cyc.push_back(cyc);
            if (bus.tx_ready === 1'b1) acc_cyc.push_back(cyc);
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        accepts = acc_cyc.size();
        check("b2b accepts", 32'(accepts), 32'(2));
        check("b2b oe_profile", 32'(oe_bad), 32'(0));
        check("b2b pulses", 32'(pulse_cyc.size()), 32'(2));
        if (accepts >= 2 && pulse_cyc.size() >= 1)
            check("b2b gap", 32'(acc_cyc[1]), 32'(pulse_cyc[0] + 1));
        check("b2b ready_after", 32'(bus.tx_ready), 32'(1));
        repeat (2) @(negedge clk);

        // Random requests and replies against the frame model.
        for (int i = 0; i < 10; i++) begin
            txb      = 8'($urandom);
            rb       = 8'($urandom);
            reply    = ($urandom_range(0, 3) != 0);
            delay    = int'($urandom_range(0, TO-3));
            bad_stop = ($urandom_range(0, 4) == 0);
            bad_par  = ($urandom_range(0, 4) == 0);
            run_txn($sformatf("rnd%0d", i), txb, reply, rb, delay, bad_stop, bad_par,
                    t_pulse, got_v, got_e, got_d);
            exp_ok = reply && !bad_stop && !(bad_par && NB == 11);
            exp_t  = reply ? delay + 2 + NB*BD : TO;
            if (exp_ok) exp_rx_data = rb;
            check($sformatf("rnd%0d latency", i), 32'(t_pulse), 32'(exp_t));
            check($sformatf("rnd%0d strobes", i), 32'({got_v, got_e}), 32'({exp_ok, !exp_ok}));
            check($sformatf("rnd%0d rx_data", i), 32'(got_d), 32'(exp_rx_data));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
